// File: rtl/outagu_if.sv
// Bundle of the control, bit-plane input and memory-write signals of outagu.
// The master side feeds configuration and planes; the slave side is the generator.
interface outagu_if #(
   parameter int N        = 64,
   parameter int BPREC    = 6,
   parameter int BDBANKA  = 15,
   parameter int BWLENGTH = 8,
   parameter int NJUMPS   = 5
);
   logic                              start;
   logic [BPREC-1:0]                  oprecision;
   logic [BDBANKA-1:0]                obaseaddr;
   logic [NJUMPS-1:0][BDBANKA-1:0]    ojump;
   logic [NJUMPS-1:1][BWLENGTH-1:0]   olength;
   logic                              in_valid;
   logic [N-1:0]                      in_data;
   logic                              busy;
   logic                              done;
   logic                              wr_en;
   logic [BDBANKA-1:0]                wr_addr;
   logic [N-1:0]                      wr_data;
   logic                              omsb;
   logic [NJUMPS-1:0]                 on_j;

   modport master (
      output start, oprecision, obaseaddr, ojump, olength, in_valid, in_data,
      input  busy, done, wr_en, wr_addr, wr_data, omsb, on_j
   );

   modport slave (
      input  start, oprecision, obaseaddr, ojump, olength, in_valid, in_data,
      output busy, done, wr_en, wr_addr, wr_data, omsb, on_j
   );
endinterface

// File: rtl/outagu.sv
// Output address generator: takes MSB-first result bit planes and writes each
// plane to base + vector offset + plane index. After the last plane of a vector
// the offset advances through a nested-loop (odometer) pattern of lengths/jumps.
module outagu #(
   parameter int N        = 64,
   parameter int BPREC    = 6,
   parameter int BDBANKA  = 15,
   parameter int BWLENGTH = 8,
   parameter int NJUMPS   = 5
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     clr,
   outagu_if.slave  bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                            state_q, state_d;
   logic [BPREC-1:0]                  last_b_q;
   logic [BPREC-1:0]                  b_q;
   logic [BDBANKA-1:0]                base_q;
   logic [BDBANKA-1:0]                voff_q;
   logic [NJUMPS-1:0][BDBANKA-1:0]    jump_q;
   logic [NJUMPS-1:1][BWLENGTH-1:0]   len_q;
   logic [NJUMPS-1:1][BWLENGTH-1:0]   cnt_q;
   logic [NJUMPS-1:1][BWLENGTH-1:0]   cnt_d;
   logic [NJUMPS-1:0]                 jsel;
   logic [BDBANKA-1:0]                jump_amt;
   logic                              carry;
   logic                              accept;
   logic                              last_plane;
   logic                              finish;

   assign accept     = (state_q == RUN) && bus.in_valid;
   assign last_plane = (b_q == last_b_q);
   assign finish     = accept && last_plane && carry;
   assign bus.busy   = (state_q == RUN);

   // Odometer step: find the lowest loop level with room left and the jump it uses.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path leaves one unassigned and infers a latch.
      cnt_d    = cnt_q;
      jsel     = '0;
      jump_amt = '0;
      // NOTE: carry is combinational scratch; blocking '=' lets each loop level see the previous level's result.
      carry    = 1'b1;
      for (int k = 1; k < NJUMPS; k++) begin
         if (carry) begin
            if (cnt_q[k] < len_q[k]) begin
               cnt_d[k]    = cnt_q[k] + BWLENGTH'(1);
               jsel[k-1]   = 1'b1;
               carry       = 1'b0;
            end else begin
               cnt_d[k] = '0;
            end
         end
      end
      jsel[NJUMPS-1] = carry;
      for (int k = 0; k < NJUMPS; k++) begin
         if (jsel[k]) jump_amt = jump_amt | jump_q[k];
      end
   end

   // Next-state: start leaves IDLE, the final plane of the final vector returns to it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.start) state_d = RUN;
         RUN:  if (finish)    state_d = IDLE;
      endcase
   end

   // State register; clr has the same effect as reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   state_q <= IDLE;
      else if (clr) state_q <= IDLE;
      // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
      else          state_q <= state_d;
   end

   // Config latch, plane/loop counters and the registered write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_b_q    <= '0;
         b_q         <= '0;
         base_q      <= '0;
         voff_q      <= '0;
         jump_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         bus.done    <= 1'b0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
         bus.omsb    <= 1'b0;
         bus.on_j    <= '0;
      end else if (clr) begin
         last_b_q    <= '0;
         b_q         <= '0;
         base_q      <= '0;
         voff_q      <= '0;
         jump_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         bus.done    <= 1'b0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
         bus.omsb    <= 1'b0;
         bus.on_j    <= '0;
      end else begin
         bus.wr_en <= 1'b0;
         bus.done  <= 1'b0;
         if (state_q == IDLE && bus.start) begin
            // A precision of 0 behaves as a single plane per vector.
            last_b_q <= (bus.oprecision == '0) ? '0 : bus.oprecision - BPREC'(1);
            base_q   <= bus.obaseaddr;
            jump_q   <= bus.ojump;
            len_q    <= bus.olength;
            b_q      <= '0;
            cnt_q    <= '0;
            voff_q   <= '0;
         end else if (accept) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= base_q + voff_q + BDBANKA'(b_q);
            bus.wr_data <= bus.in_data;
            bus.omsb    <= (b_q == '0);
            if (last_plane) begin
               b_q      <= '0;
               cnt_q    <= cnt_d;
               voff_q   <= voff_q + jump_amt;
               bus.on_j <= jsel;
               bus.done <= carry;
            end else begin
               b_q <= b_q + BPREC'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_outagu.sv
// Self-checking bench for outagu: directed scenarios plus randomized runs, all
// compared against a closed-form model of the nested address loops.
module tb_outagu;
   localparam int N        = 64;
   localparam int BPREC    = 6;
   localparam int BDBANKA  = 15;
   localparam int BWLENGTH = 8;
   localparam int NJUMPS   = 5;

   typedef struct packed {
      logic [BDBANKA-1:0] addr;
      logic [N-1:0]       data;
      logic               omsb;
      logic [NJUMPS-1:0]  on_j;
      logic               done;
      logic               busy;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr = 1'b0;

   outagu_if #(.N(N), .BPREC(BPREC), .BDBANKA(BDBANKA), .BWLENGTH(BWLENGTH), .NJUMPS(NJUMPS)) bus ();

   outagu #(.N(N), .BPREC(BPREC), .BDBANKA(BDBANKA), .BWLENGTH(BWLENGTH), .NJUMPS(NJUMPS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int                n_checks = 0;
   int                n_fail   = 0;
   int                n_done_alone = 0;
   wr_t               obs_q[$];
   wr_t               exp_q[$];
   logic [N-1:0]      fed_q[$];
   logic [NJUMPS-1:0] model_onj = '0;

   int cfg_p;
   int cfg_base;
   int cfg_jump[NJUMPS];
   int cfg_len[NJUMPS];

   // Monitor: record every write, count done pulses that arrive without one.
   always @(negedge clk) begin
      if (bus.wr_en)
         obs_q.push_back(wr_t'({bus.wr_addr, bus.wr_data, bus.omsb, bus.on_j, bus.done, bus.busy}));
      else if (bus.done)
         n_done_alone++;
   end

   function automatic longint total_planes();
      longint t;
      t = (cfg_p == 0) ? 1 : cfg_p;
      for (int k = 1; k < NJUMPS; k++) t = t * (cfg_len[k] + 1);
      return t;
   endfunction

   // Reference model: vector v is a mixed-radix number; level k advanced
   // floor(v/M[k-1]) - floor(v/M[k]) times before it, each adding jump[k-1].
   task automatic build_expected();
      longint p, voff;
      longint m[NJUMPS];
      int     idx, k_used;
      wr_t    e;
      exp_q.delete();
      idx  = 0;
      p    = (cfg_p == 0) ? 1 : cfg_p;
      m[0] = 1;
      for (int k = 1; k < NJUMPS; k++) m[k] = m[k-1] * (cfg_len[k] + 1);
      for (longint v = 0; v < m[NJUMPS-1]; v++) begin
         voff = 0;
         for (int k = 1; k < NJUMPS; k++) voff += (v / m[k-1] - v / m[k]) * cfg_jump[k-1];
         k_used = NJUMPS - 1;
         for (int k = NJUMPS - 1; k >= 1; k--)
            if ((v / m[k-1]) % (cfg_len[k] + 1) != cfg_len[k]) k_used = k - 1;
         for (longint b = 0; b < p; b++) begin
            e.addr = BDBANKA'(cfg_base + voff + b);
            e.data = (idx < fed_q.size()) ? fed_q[idx] : '0;
            idx++;
            e.omsb = (b == 0);
            if (b == p - 1) model_onj = NJUMPS'(1) << k_used;
            e.on_j = model_onj;
            e.done = (b == p - 1) && (v == m[NJUMPS-1] - 1);
            e.busy = !e.done;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic clear_cfg();
      cfg_p = 1;
      cfg_base = 0;
      for (int k = 0; k < NJUMPS; k++) begin
         cfg_jump[k] = 0;
         cfg_len[k]  = 0;
      end
   endtask

   // Pulse start with the config; a plane offered in the same cycle must be dropped.
   task automatic start_run();
      @(negedge clk);
      obs_q.delete();
      fed_q.delete();
      n_done_alone = 0;
      bus.oprecision = BPREC'(cfg_p);
      bus.obaseaddr  = BDBANKA'(cfg_base);
      for (int k = 0; k < NJUMPS; k++) bus.ojump[k] = BDBANKA'(cfg_jump[k]);
      for (int k = 1; k < NJUMPS; k++) bus.olength[k] = BWLENGTH'(cfg_len[k]);
      bus.start    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = {$urandom, $urandom};
      @(negedge clk);
      bus.start      = 1'b0;
      bus.in_valid   = 1'b0;
      bus.oprecision = BPREC'($urandom);
      bus.obaseaddr  = BDBANKA'($urandom);
      for (int k = 0; k < NJUMPS; k++) bus.ojump[k] = BDBANKA'($urandom);
      for (int k = 1; k < NJUMPS; k++) bus.olength[k] = BWLENGTH'($urandom);
   endtask

   // Offer n planes with random idle gaps; optionally re-pulse start while running.
   task automatic feed(input longint n, input int gap_max, input bit poke);
      for (longint i = 0; i < n; i++) begin
         repeat ($urandom_range(0, gap_max)) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.start    = poke && ($urandom_range(0, 1) == 1);
         end
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = {$urandom, $urandom};
         fed_q.push_back(bus.in_data);
         bus.start    = poke && (i != n - 1) && ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, bus.wr_en, bus.wr_addr, bus.wr_data, bus.omsb, bus.on_j} !== '0) begin
         n_fail++;
         $display("FAIL reset_idle: outputs %h, want all zero",
                  {bus.busy, bus.done, bus.wr_en, bus.wr_addr, bus.wr_data, bus.omsb, bus.on_j});
      end
      clear_cfg();
      cfg_p = 4; cfg_base = 'h55; cfg_len[1] = 2; cfg_jump[0] = 9;
      start_run();
      feed(5, 0, 0);
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_prebusy: busy %b, want 1", bus.busy);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.wr_en, bus.wr_addr, bus.wr_data, bus.omsb, bus.on_j} !== '0) begin
         n_fail++;
         $display("FAIL reset_async: outputs %h, want all zero",
                  {bus.busy, bus.done, bus.wr_en, bus.wr_addr, bus.wr_data, bus.omsb, bus.on_j});
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_onj = '0;
      obs_q.delete();
      repeat (4) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (obs_q.size() !== 0) begin
         n_fail++;
         $display("FAIL reset_idle_drop: %0d writes after reset, want 0", obs_q.size());
      end
   endtask

   task automatic test_basic();
      logic [BDBANKA-1:0] want_addr[4];
      want_addr = '{15'h100, 15'h101, 15'h104, 15'h105};
      clear_cfg();
      cfg_p = 2; cfg_base = 'h100; cfg_jump[0] = 4; cfg_jump[1] = 0; cfg_len[1] = 1; cfg_jump[4] = 3;
      start_run();
      feed(total_planes(), 0, 0);
      build_expected();
      n_checks++;
      if (obs_q.size() !== 4) begin
         n_fail++;
         $display("FAIL basic_count: got %0d writes, want 4", obs_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         n_checks++;
         if (obs_q[i].addr !== want_addr[i] || obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL basic_wr%0d: got %h, want %h (addr %h)", i, obs_q[i], exp_q[i], want_addr[i]);
         end
      end
   endtask

   task automatic test_p0();
      clear_cfg();
      cfg_p = 0; cfg_base = 'h200; cfg_jump[0] = 3; cfg_len[1] = 2; cfg_jump[4] = 1;
      start_run();
      feed(total_planes(), 1, 0);
      build_expected();
      n_checks++;
      if (obs_q.size() !== 3) begin
         n_fail++;
         $display("FAIL p0_count: got %0d writes, want 3", obs_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         n_checks++;
         if (obs_q[i].addr !== BDBANKA'('h200 + 3 * i) || obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL p0_wr%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [BDBANKA-1:0] want_addr[4];
      want_addr = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
      clear_cfg();
      cfg_p = 4; cfg_base = 'h7FFE; cfg_jump[4] = 'h1234;
      start_run();
      feed(total_planes(), 2, 0);
      build_expected();
      n_checks++;
      if (obs_q.size() !== 4) begin
         n_fail++;
         $display("FAIL wrap_count: got %0d writes, want 4", obs_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         n_checks++;
         if (obs_q[i].addr !== want_addr[i] || obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL wrap_wr%0d: got %h, want %h (addr %h)", i, obs_q[i], exp_q[i], want_addr[i]);
         end
      end
   endtask

   task automatic test_nested();
      logic [BDBANKA-1:0] want_addr[4];
      logic [NJUMPS-1:0]  want_onj[4];
      want_addr = '{15'd0, 15'd2, 15'd12, 15'd14};
      want_onj  = '{5'b00001, 5'b00010, 5'b00001, 5'b10000};
      clear_cfg();
      cfg_p = 1; cfg_len[1] = 1; cfg_len[2] = 1; cfg_jump[0] = 2; cfg_jump[1] = 10;
      cfg_jump[2] = 100; cfg_jump[3] = 200; cfg_jump[4] = 7;
      start_run();
      feed(total_planes(), 0, 0);
      build_expected();
      n_checks++;
      if (obs_q.size() !== 4) begin
         n_fail++;
         $display("FAIL nested_count: got %0d writes, want 4", obs_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         n_checks++;
         if (obs_q[i].addr !== want_addr[i] || obs_q[i].on_j !== want_onj[i] ||
             obs_q[i].done !== (i == 3) || obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL nested_wr%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
         end
      end
      n_checks++;
      if (n_done_alone !== 0) begin
         n_fail++;
         $display("FAIL nested_done_alone: %0d stray done pulses, want 0", n_done_alone);
      end
   endtask

   task automatic test_clr();
      clear_cfg();
      cfg_p = 2; cfg_base = 'h40; cfg_len[1] = 3; cfg_jump[0] = 8;
      start_run();
      repeat (3) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = {$urandom, $urandom};
         fed_q.push_back(bus.in_data);
      end
      @(negedge clk);
      clr = 1'b1;
      bus.in_data = {$urandom, $urandom};
      @(negedge clk);
      clr = 1'b0;
      repeat (5) begin
         @(negedge clk);
         bus.in_data = {$urandom, $urandom};
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      build_expected();
      model_onj = '0;
      n_checks++;
      if (obs_q.size() !== 3 || n_done_alone !== 0) begin
         n_fail++;
         $display("FAIL clr_count: got %0d writes / %0d done, want 3 / 0", obs_q.size(), n_done_alone);
      end
      for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL clr_wr%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
         end
      end
      n_checks++;
      if (bus.busy !== 1'b0 || bus.on_j !== '0) begin
         n_fail++;
         $display("FAIL clr_state: busy %b on_j %b, want 0 00000", bus.busy, bus.on_j);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 5; r++) begin
         clear_cfg();
         cfg_p    = $urandom_range(0, 5);
         cfg_base = $urandom_range(0, 32767);
         for (int k = 0; k < NJUMPS; k++) cfg_jump[k] = $urandom_range(0, 32767);
         for (int k = 1; k < NJUMPS; k++) cfg_len[k] = $urandom_range(0, 2);
         start_run();
         feed(total_planes(), 2, 1);
         build_expected();
         n_checks++;
         if (obs_q.size() !== exp_q.size() || n_done_alone !== 0) begin
            n_fail++;
            $display("FAIL rand%0d_count: got %0d writes / %0d stray done, want %0d / 0",
                     r, obs_q.size(), n_done_alone, exp_q.size());
         end
         foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL rand%0d_wr%0d: got %h, want %h", r, i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.oprecision = '0;
      bus.obaseaddr  = '0;
      bus.ojump      = '0;
      bus.olength    = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_basic();
      test_p0();
      test_wrap();
      test_nested();
      test_clr();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
